// File: rtl/cosim_trace_emitter.sv
`default_nettype none
// ============================================================================
// Module      : cosim_trace_emitter
// Description : Producer side of the co-simulation commit interface. Captures
//               WB-stage retirements (with MMIO store detection) and taken
//               interrupts, queues them in program order and emits one event
//               per cycle on the cosim bus. Latches the first checker error.
// Revision    : 1.0 - initial release
// ============================================================================
module cosim_trace_emitter #(
    parameter int          XLEN      = 64,
    parameter int          DEPTH     = 8,
    parameter logic [63:0] MMIO_BASE = 64'h1000_0000,
    parameter logic [63:0] MMIO_SIZE = 64'h1000
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_wb_valid,
    input  logic [XLEN-1:0] i_wb_pc,
    input  logic [31:0]     i_wb_inst,
    input  logic            i_wb_we,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_wdata,
    input  logic            i_wb_store,
    input  logic [XLEN-1:0] i_wb_store_addr,
    input  logic [3:0]      i_wb_store_len,
    input  logic [XLEN-1:0] i_wb_store_data,
    input  logic            i_irq_take,
    input  logic [XLEN-1:0] i_irq_cause,
    input  logic            i_chk_error,
    output logic            o_trace_stall,
    output logic            o_cosim_valid,
    output logic [63:0]     o_cosim_pc,
    output logic [31:0]     o_cosim_inst,
    output logic            o_cosim_we,
    output logic [4:0]      o_cosim_rd,
    output logic [63:0]     o_cosim_wdate,
    output logic            o_cosim_mmio_store,
    output logic [63:0]     o_cosim_mmio_len,
    output logic [63:0]     o_cosim_mmio_val,
    output logic [63:0]     o_cosim_mmio_addr,
    output logic            o_cosim_interrupt,
    output logic [63:0]     o_cosim_cause,
    output logic            o_overflow,
    output logic            o_err_valid,
    output logic [63:0]     o_err_pc,
    output logic [63:0]     o_instret
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // One queue slot. For interrupt entries the cause travels in 'data'.
    typedef struct packed {
        logic        is_irq;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        we;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        mmio;
        logic [3:0]  len;
        logic [63:0] val;
        logic [63:0] addr;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;

    logic            r_cosim_valid;
    logic [63:0]     r_cosim_pc;
    logic [31:0]     r_cosim_inst;
    logic            r_cosim_we;
    logic [4:0]      r_cosim_rd;
    logic [63:0]     r_cosim_wdate;
    logic            r_cosim_mmio_store;
    logic [63:0]     r_cosim_mmio_len;
    logic [63:0]     r_cosim_mmio_val;
    logic [63:0]     r_cosim_mmio_addr;
    logic            r_cosim_interrupt;
    logic [63:0]     r_cosim_cause;
    logic            r_overflow;
    logic            r_err_valid;
    logic [63:0]     r_err_pc;
    logic [63:0]     r_instret;

    logic [63:0]     w_store_addr64;
    logic [63:0]     w_mmio_off;
    logic            w_in_mmio;
    logic [63:0]     w_len_mask;
    entry_t          w_commit;
    entry_t          w_irq;
    entry_t          w_slot0;
    entry_t          w_head;
    logic            w_empty;
    logic            w_pop;
    logic [PW-1:0]   w_used;
    logic [PW:0]     w_free;
    logic            w_req0;
    logic            w_req1;
    logic            w_acc0;
    logic            w_acc1;
    logic            w_drop;
    logic [AW-1:0]   w_wr_idx0;
    logic [AW-1:0]   w_wr_idx1;

    // MMIO window test is a single unsigned subtract so addresses below the
    // base wrap to huge offsets and fall outside the window.
    assign w_store_addr64 = 64'(i_wb_store_addr);
    assign w_mmio_off     = w_store_addr64 - MMIO_BASE;
    assign w_in_mmio      = i_wb_store && (w_mmio_off < MMIO_SIZE);

    // Byte mask for the store value; 8 or more bytes keeps the whole word.
    assign w_len_mask = (i_wb_store_len >= 4'd8) ? 64'hFFFF_FFFF_FFFF_FFFF
                      : ((64'd1 << {i_wb_store_len[2:0], 3'b000}) - 64'd1);

    // Build the commit and interrupt entries from the WB-stage inputs.
    always_comb begin
        w_commit        = '0;
        w_commit.is_irq = 1'b0;
        w_commit.pc     = 64'(i_wb_pc);
        w_commit.inst   = i_wb_inst;
        w_commit.we     = i_wb_we && (i_wb_rd != 5'd0);
        w_commit.rd     = i_wb_rd;
        w_commit.data   = 64'(i_wb_wdata);
        w_commit.mmio   = w_in_mmio;
        w_commit.len    = i_wb_store_len;
        w_commit.val    = 64'(i_wb_store_data) & w_len_mask;
        w_commit.addr   = w_store_addr64;

        w_irq           = '0;
        w_irq.is_irq    = 1'b1;
        w_irq.data      = 64'(i_irq_cause);
    end

    // Occupancy: the head is always popped when present, so the free count
    // seen by this cycle's pushes includes the slot being vacated.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_pop     = !w_empty;
    assign w_used    = r_wr_ptr - r_rd_ptr;
    assign w_free    = (PW+1)'(DEPTH) - {1'b0, w_used} + {{PW{1'b0}}, w_pop};
    assign o_trace_stall = (w_free < (PW+1)'(2));

    // Commit goes into the first slot so the older instruction precedes the trap.
    assign w_req0    = i_wb_valid | i_irq_take;
    assign w_req1    = i_wb_valid & i_irq_take;
    assign w_acc0    = w_req0 && (w_free >= (PW+1)'(1));
    assign w_acc1    = w_req1 && (w_free >= (PW+1)'(2));
    assign w_drop    = (w_req0 && !w_acc0) || (w_req1 && !w_acc1);
    assign w_slot0   = i_wb_valid ? w_commit : w_irq;
    assign w_wr_idx0 = r_wr_ptr[AW-1:0];
    assign w_wr_idx1 = w_wr_idx0 + AW'(1);
    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Queue storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (rstn) begin
            if (w_acc0) begin
                r_mem[w_wr_idx0] <= w_slot0;
            end
            if (w_acc1) begin
                r_mem[w_wr_idx1] <= w_irq;
            end
        end
    end

    // Queue pointers: up to two pushes and one pop per cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_acc0) + PW'(w_acc1);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
        end
    end

    // Output stage: load the head entry; payloads hold when nothing is emitted.
    // instret counts an event in the same cycle it appears on the bus.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cosim_valid      <= 1'b0;
            r_cosim_pc         <= '0;
            r_cosim_inst       <= '0;
            r_cosim_we         <= 1'b0;
            r_cosim_rd         <= '0;
            r_cosim_wdate      <= '0;
            r_cosim_mmio_store <= 1'b0;
            r_cosim_mmio_len   <= '0;
            r_cosim_mmio_val   <= '0;
            r_cosim_mmio_addr  <= '0;
            r_cosim_interrupt  <= 1'b0;
            r_cosim_cause      <= '0;
            r_instret          <= '0;
        end else begin
            r_cosim_valid     <= w_pop && !w_head.is_irq;
            r_cosim_interrupt <= w_pop && w_head.is_irq;
            if (w_pop) begin
                if (w_head.is_irq) begin
                    r_cosim_cause <= w_head.data;
                end else begin
                    r_cosim_pc         <= w_head.pc;
                    r_cosim_inst       <= w_head.inst;
                    r_cosim_we         <= w_head.we;
                    r_cosim_rd         <= w_head.rd;
                    r_cosim_wdate      <= w_head.data;
                    r_cosim_mmio_store <= w_head.mmio;
                    r_cosim_mmio_len   <= 64'(w_head.len);
                    r_cosim_mmio_val   <= w_head.val;
                    r_cosim_mmio_addr  <= w_head.addr;
                    r_instret          <= r_instret + 64'd1;
                end
            end
        end
    end

    // Sticky status: overflow on any dropped push, first checker error with its pc.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_overflow  <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_pc    <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (!r_err_valid && i_chk_error) begin
                r_err_valid <= 1'b1;
                r_err_pc    <= r_cosim_pc;
            end
        end
    end

    assign o_cosim_valid      = r_cosim_valid;
    assign o_cosim_pc         = r_cosim_pc;
    assign o_cosim_inst       = r_cosim_inst;
    assign o_cosim_we         = r_cosim_we;
    assign o_cosim_rd         = r_cosim_rd;
    assign o_cosim_wdate      = r_cosim_wdate;
    assign o_cosim_mmio_store = r_cosim_mmio_store;
    assign o_cosim_mmio_len   = r_cosim_mmio_len;
    assign o_cosim_mmio_val   = r_cosim_mmio_val;
    assign o_cosim_mmio_addr  = r_cosim_mmio_addr;
    assign o_cosim_interrupt  = r_cosim_interrupt;
    assign o_cosim_cause      = r_cosim_cause;
    assign o_overflow         = r_overflow;
    assign o_err_valid        = r_err_valid;
    assign o_err_pc           = r_err_pc;
    assign o_instret          = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_cosim_trace_emitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cosim_trace_emitter
// Description : Self-checking bench for cosim_trace_emitter. Single-event
//               vectors from a table, then sequences for ordering, fill and
//               overflow, mid-operation reset and error latching.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cosim_trace_emitter;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wb_valid, wb_we, wb_store, irq_take, chk_error;
    logic [63:0] wb_pc, wb_wdata, wb_store_addr, wb_store_data, irq_cause;
    logic [31:0] wb_inst;
    logic [4:0]  wb_rd;
    logic [3:0]  wb_store_len;

    logic        trace_stall, cosim_valid, cosim_we, cosim_mmio_store, cosim_interrupt;
    logic        overflow, err_valid;
    logic [63:0] cosim_pc, cosim_wdate, cosim_mmio_len, cosim_mmio_val, cosim_mmio_addr;
    logic [63:0] cosim_cause, err_pc, instret;
    logic [31:0] cosim_inst;
    logic [4:0]  cosim_rd;

    int checks   = 0;
    int failures = 0;

    cosim_trace_emitter #(.XLEN(64), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .i_wb_valid        (wb_valid),
        .i_wb_pc           (wb_pc),
        .i_wb_inst         (wb_inst),
        .i_wb_we           (wb_we),
        .i_wb_rd           (wb_rd),
        .i_wb_wdata        (wb_wdata),
        .i_wb_store        (wb_store),
        .i_wb_store_addr   (wb_store_addr),
        .i_wb_store_len    (wb_store_len),
        .i_wb_store_data   (wb_store_data),
        .i_irq_take        (irq_take),
        .i_irq_cause       (irq_cause),
        .i_chk_error       (chk_error),
        .o_trace_stall     (trace_stall),
        .o_cosim_valid     (cosim_valid),
        .o_cosim_pc        (cosim_pc),
        .o_cosim_inst      (cosim_inst),
        .o_cosim_we        (cosim_we),
        .o_cosim_rd        (cosim_rd),
        .o_cosim_wdate     (cosim_wdate),
        .o_cosim_mmio_store(cosim_mmio_store),
        .o_cosim_mmio_len  (cosim_mmio_len),
        .o_cosim_mmio_val  (cosim_mmio_val),
        .o_cosim_mmio_addr (cosim_mmio_addr),
        .o_cosim_interrupt (cosim_interrupt),
        .o_cosim_cause     (cosim_cause),
        .o_overflow        (overflow),
        .o_err_valid       (err_valid),
        .o_err_pc          (err_pc),
        .o_instret         (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wb_valid = 0; wb_pc = '0; wb_inst = '0; wb_we = 0; wb_rd = '0; wb_wdata = '0;
        wb_store = 0; wb_store_addr = '0; wb_store_len = '0; wb_store_data = '0;
        irq_take = 0; irq_cause = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " valid"},     64'(cosim_valid), 64'd0);
        check({tag, " interrupt"}, 64'(cosim_interrupt), 64'd0);
        check({tag, " pc"},        cosim_pc, 64'd0);
        check({tag, " inst"},      64'(cosim_inst), 64'd0);
        check({tag, " we"},        64'(cosim_we), 64'd0);
        check({tag, " rd"},        64'(cosim_rd), 64'd0);
        check({tag, " wdate"},     cosim_wdate, 64'd0);
        check({tag, " mmio"},      64'(cosim_mmio_store), 64'd0);
        check({tag, " mmio_len"},  cosim_mmio_len, 64'd0);
        check({tag, " mmio_val"},  cosim_mmio_val, 64'd0);
        check({tag, " mmio_addr"}, cosim_mmio_addr, 64'd0);
        check({tag, " cause"},     cosim_cause, 64'd0);
        check({tag, " overflow"},  64'(overflow), 64'd0);
        check({tag, " err_valid"}, 64'(err_valid), 64'd0);
        check({tag, " err_pc"},    err_pc, 64'd0);
        check({tag, " instret"},   instret, 64'd0);
        check({tag, " stall"},     64'(trace_stall), 64'd0);
    endtask

    // Expected-event scoreboard for the multi-cycle sequences.
    typedef struct {
        bit          irq;
        logic [63:0] v;
    } ev_t;
    ev_t q[$];
    int  exp_instret = 0;
    bit  exp_ovf     = 0;

    // Drive one cycle of commit/irq requests and check what the bus shows after the edge.
    task automatic mstep(input bit c_valid, input logic [63:0] c_pc,
                         input bit i_take, input logic [63:0] cause);
        bit  pop;
        int  cap;
        int  used;
        ev_t h;
        wb_valid = c_valid; wb_pc = c_pc; wb_inst = 32'h0000_0013;
        irq_take = i_take;  irq_cause = cause;
        pop = (q.size() > 0);
        cap = DEPTH - q.size() + (pop ? 1 : 0);
        step();
        if (pop) begin
            h = q.pop_front();
            if (h.irq) begin
                check("seq irq interrupt", 64'(cosim_interrupt), 64'd1);
                check("seq irq valid",     64'(cosim_valid), 64'd0);
                check("seq irq cause",     cosim_cause, h.v);
            end else begin
                exp_instret++;
                check("seq commit valid",     64'(cosim_valid), 64'd1);
                check("seq commit interrupt", 64'(cosim_interrupt), 64'd0);
                check("seq commit pc",        cosim_pc, h.v);
            end
        end else begin
            check("seq idle valid",     64'(cosim_valid), 64'd0);
            check("seq idle interrupt", 64'(cosim_interrupt), 64'd0);
        end
        if (c_valid) begin
            if (cap > 0) begin q.push_back('{irq: 1'b0, v: c_pc}); cap--; end
            else exp_ovf = 1;
        end
        if (i_take) begin
            if (cap > 0) begin q.push_back('{irq: 1'b1, v: cause}); cap--; end
            else exp_ovf = 1;
        end
        used = q.size();
        check("seq instret",  instret, 64'(exp_instret));
        check("seq overflow", 64'(overflow), 64'(exp_ovf));
        check("seq stall",    64'(trace_stall), 64'((DEPTH - used + ((used > 0) ? 1 : 0)) < 2));
        clear_inputs();
    endtask

    function automatic bit model_stall();
        int used = q.size();
        return (DEPTH - used + ((used > 0) ? 1 : 0)) < 2;
    endfunction

    typedef struct {
        string       name;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        we;
        logic [4:0]  rd;
        logic [63:0] wdata;
        logic        st;
        logic [63:0] saddr;
        logic [3:0]  slen;
        logic [63:0] sdata;
        logic        e_we;
        logic        e_mmio;
        logic [63:0] e_val;
    } vec_t;

    vec_t tv[9];

    initial begin
        tv[0] = '{"single",    64'h8000_0000, 32'h0050_0093, 1'b1, 5'd1, 64'd5,  1'b0, 64'h0,           4'd0, 64'h0,                  1'b1, 1'b0, 64'h0};
        tv[1] = '{"rd0",       64'h8000_0004, 32'h0070_0013, 1'b1, 5'd0, 64'd7,  1'b0, 64'h0,           4'd0, 64'h0,                  1'b0, 1'b0, 64'h0};
        tv[2] = '{"mmio_sb",   64'h8000_0008, 32'h00b5_0023, 1'b0, 5'd0, 64'd0,  1'b1, 64'h1000_0004,   4'd1, 64'h1234,               1'b0, 1'b1, 64'h34};
        tv[3] = '{"ram_sw",    64'h8000_000c, 32'h00b5_2023, 1'b0, 5'd0, 64'd0,  1'b1, 64'h8000_1000,   4'd4, 64'h1234,               1'b0, 1'b0, 64'h0};
        tv[4] = '{"mmio_top",  64'h8000_0010, 32'h00b5_1023, 1'b0, 5'd0, 64'd0,  1'b1, 64'h1000_0ffe,   4'd2, 64'hdead_beef,          1'b0, 1'b1, 64'hbeef};
        tv[5] = '{"mmio_past", 64'h8000_0014, 32'h00b5_2023, 1'b0, 5'd0, 64'd0,  1'b1, 64'h1000_1000,   4'd4, 64'h55,                 1'b0, 1'b0, 64'h0};
        tv[6] = '{"mmio_below",64'h8000_0018, 32'h00b5_2023, 1'b0, 5'd0, 64'd0,  1'b1, 64'h0fff_fffc,   4'd4, 64'h66,                 1'b0, 1'b0, 64'h0};
        tv[7] = '{"mmio_sd",   64'h8000_001c, 32'h00b5_3023, 1'b0, 5'd0, 64'd0,  1'b1, 64'h1000_0000,   4'd8, 64'h0123_4567_89ab_cdef, 1'b0, 1'b1, 64'h0123_4567_89ab_cdef};
        tv[8] = '{"mmio_sw",   64'h8000_0020, 32'h00b5_2423, 1'b0, 5'd0, 64'd0,  1'b1, 64'h1000_0008,   4'd4, 64'hffff_ffff_1234_5678, 1'b0, 1'b1, 64'h1234_5678};

        clear_inputs();
        chk_error = 0;
        rstn = 0;
        step();
        step();
        check_all_zero("reset");
        rstn = 1;

        // Single events from the table: push, one idle cycle, then on the bus.
        for (int i = 0; i < 9; i++) begin
            wb_valid = 1; wb_pc = tv[i].pc; wb_inst = tv[i].inst; wb_we = tv[i].we;
            wb_rd = tv[i].rd; wb_wdata = tv[i].wdata; wb_store = tv[i].st;
            wb_store_addr = tv[i].saddr; wb_store_len = tv[i].slen; wb_store_data = tv[i].sdata;
            step();
            clear_inputs();
            check({tv[i].name, " valid early"}, 64'(cosim_valid), 64'd0);
            step();
            exp_instret++;
            check({tv[i].name, " valid"},     64'(cosim_valid), 64'd1);
            check({tv[i].name, " interrupt"}, 64'(cosim_interrupt), 64'd0);
            check({tv[i].name, " pc"},        cosim_pc, tv[i].pc);
            check({tv[i].name, " inst"},      64'(cosim_inst), 64'(tv[i].inst));
            check({tv[i].name, " we"},        64'(cosim_we), 64'(tv[i].e_we));
            check({tv[i].name, " rd"},        64'(cosim_rd), 64'(tv[i].rd));
            check({tv[i].name, " wdate"},     cosim_wdate, tv[i].wdata);
            check({tv[i].name, " mmio"},      64'(cosim_mmio_store), 64'(tv[i].e_mmio));
            if (tv[i].e_mmio) begin
                check({tv[i].name, " mmio_len"},  cosim_mmio_len, 64'(tv[i].slen));
                check({tv[i].name, " mmio_val"},  cosim_mmio_val, tv[i].e_val);
                check({tv[i].name, " mmio_addr"}, cosim_mmio_addr, tv[i].saddr);
            end
            check({tv[i].name, " instret"},   instret, 64'(exp_instret));
            step();
            check({tv[i].name, " valid drop"}, 64'(cosim_valid), 64'd0);
            check({tv[i].name, " pc hold"},    cosim_pc, tv[i].pc);
        end

        // Commit and interrupt in the same cycle: commit first, then the trap.
        mstep(1, 64'h100, 1, 64'h8000_0000_0000_0007);
        mstep(0, 64'h0, 0, 64'h0);
        mstep(0, 64'h0, 0, 64'h0);
        check("order pc hold during irq", cosim_pc, 64'h100);
        mstep(0, 64'h0, 0, 64'h0);

        // Fill with two pushes per cycle until the stall, then force one more.
        for (int c = 0; c < 20 && !model_stall(); c++) begin
            mstep(1, 64'h1000 + 64'(8 * c), 1, 64'(c));
        end
        check("fill used at stall", 64'(q.size()), 64'(DEPTH));
        check("fill overflow before force", 64'(overflow), 64'd0);
        mstep(1, 64'h2000, 1, 64'h99);
        check("fill overflow after force", 64'(overflow), 64'd1);
        for (int c = 0; c < DEPTH + 2; c++) begin
            mstep(0, 64'h0, 0, 64'h0);
        end

        // Reset with five events queued drops them all.
        for (int c = 0; c < 4; c++) begin
            mstep(1, 64'h3000 + 64'(8 * c), 1, 64'(64'h40 + 64'(c)));
        end
        check("reset pre queued", 64'(q.size()), 64'd5);
        rstn = 0;
        step();
        rstn = 1;
        q.delete();
        exp_instret = 0;
        exp_ovf = 0;
        check_all_zero("midreset");
        mstep(0, 64'h0, 0, 64'h0);

        // First checker error latches the pc on the bus at that moment.
        mstep(1, 64'h204, 0, 64'h0);
        mstep(1, 64'h208, 0, 64'h0);
        check("err before pulse", 64'(err_valid), 64'd0);
        chk_error = 1;
        mstep(0, 64'h0, 0, 64'h0);
        chk_error = 0;
        check("err valid", 64'(err_valid), 64'd1);
        check("err pc",    err_pc, 64'h204);
        mstep(1, 64'h300, 0, 64'h0);
        mstep(0, 64'h0, 0, 64'h0);
        chk_error = 1;
        mstep(0, 64'h0, 0, 64'h0);
        chk_error = 0;
        check("err valid sticky", 64'(err_valid), 64'd1);
        check("err pc held",      err_pc, 64'h204);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
